// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Load/store front-end driving the RAM MOV/RW/MOC handshake,
//            with op3 decode, alignment check and MOC timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [5:0]        op3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [1:0]        err,
    output logic              err_v,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_datain,
    input  logic [31:0]       mem_dataout,
    input  logic              mem_moc
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [1:0] c_ST_ERR  = 2'd3;

    localparam int               c_CNT_W    = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;

    logic               w_legal;
    logic               w_rd;
    logic [1:0]         w_size;
    logic               w_sign;
    logic               w_misalign;

    always_comb begin
        w_legal = 1'b1;
        w_rd    = 1'b1;
        w_size  = 2'b00;
        w_sign  = 1'b0;
        case (op3)
            6'b001001: begin w_size = 2'b00; w_sign = 1'b1; end
            6'b001010: begin w_size = 2'b01; w_sign = 1'b1; end
            6'b000001: w_size = 2'b00;
            6'b000010: w_size = 2'b01;
            6'b000000: w_size = 2'b10;
            6'b000101: begin w_rd = 1'b0; w_size = 2'b00; end
            6'b000110: begin w_rd = 1'b0; w_size = 2'b01; end
            6'b000100: begin w_rd = 1'b0; w_size = 2'b10; end
            default:   w_legal = 1'b0;
        endcase
    end

    assign w_misalign = ((w_size == 2'b01) && addr[0]) ||
                        ((w_size == 2'b10) && (addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata       <= 32'd0;
            err         <= 2'b00;
            err_v       <= 1'b0;
            mem_mov     <= 1'b0;
            mem_rw      <= 1'b0;
            mem_size    <= 2'b00;
            mem_sign    <= 1'b0;
            mem_address <= '0;
            mem_datain  <= 32'd0;
        end else begin
            done  <= 1'b0;
            err_v <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    mem_mov <= 1'b0;
                    if (req) begin
                        mem_rw      <= w_rd;
                        mem_size    <= w_size;
                        mem_sign    <= w_sign;
                        mem_address <= addr;
                        mem_datain  <= wdata;
                        r_count     <= '0;
                        busy        <= 1'b1;
                        // Illegal opcode outranks misalignment
                        if (!w_legal) begin
                            r_state <= c_ST_ERR;
                            err     <= 2'b11;
                            err_v   <= 1'b1;
                        end else if (w_misalign) begin
                            r_state <= c_ST_ERR;
                            err     <= 2'b01;
                            err_v   <= 1'b1;
                        end else begin
                            r_state <= c_ST_WAIT;
                            err     <= 2'b00;
                            mem_mov <= 1'b1;
                        end
                    end
                end
                c_ST_WAIT: begin
                    r_count <= r_count + 1'b1;
                    // First WAIT cycle may still see MOC from the prior access
                    if ((r_count != '0) && mem_moc) begin
                        if (mem_rw) begin
                            rdata <= mem_dataout;
                        end
                        mem_mov <= 1'b0;
                        done    <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else if (r_count == c_CNT_LAST) begin
                        mem_mov <= 1'b0;
                        err     <= 2'b10;
                        err_v   <= 1'b1;
                        r_state <= c_ST_ERR;
                    end
                end
                c_ST_DONE: begin
                    mem_mov <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    mem_mov <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Self-checking bench for mem_access_ctrl with a byte RAM responder
//            and a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [5:0]  op3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err_v, mem_mov, mem_rw, mem_sign;
    logic [31:0] rdata, mem_address, mem_datain;
    logic [1:0]  err, mem_size;
    logic [31:0] mem_dataout = '0;
    logic        mem_moc = 1'b0;

    mem_access_ctrl #(.TIMEOUT(c_TO), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .op3(op3), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
        .err_v(err_v), .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_size(mem_size),
        .mem_sign(mem_sign), .mem_address(mem_address), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout), .mem_moc(mem_moc)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [7:0]  ram     [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] ref_rdata = '0;
    logic [1:0]  last_err;
    logic [31:0] last_rd;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        int          d;
        bit          stale;
        logic [1:0]  exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void op_info(input logic [5:0] op, output bit legal,
                                    output int nb, output bit ld, output bit sg);
        legal = 1'b1; nb = 4; ld = 1'b1; sg = 1'b0;
        case (op)
            6'b001001: begin nb = 1; sg = 1'b1; end
            6'b001010: begin nb = 2; sg = 1'b1; end
            6'b000001: nb = 1;
            6'b000010: nb = 2;
            6'b000000: nb = 4;
            6'b000101: begin nb = 1; ld = 1'b0; end
            6'b000110: begin nb = 2; ld = 1'b0; end
            6'b000100: begin nb = 4; ld = 1'b0; end
            default:   legal = 1'b0;
        endcase
    endfunction

    // RAM side: acts purely on what the DUT presents on the mem_* pins
    task automatic ram_respond();
        int     nb;
        longint v;
        nb = (mem_size == 2'b00) ? 1 : (mem_size == 2'b01) ? 2 : 4;
        if (mem_rw) begin
            v = 0;
            for (int i = 0; i < nb; i++)
                v = v * 256 + longint'(ram[(int'(mem_address[7:0]) + i) % 256]);
            if (mem_sign && v >= (64'sd1 << (8 * nb - 1)))
                v = v - (64'sd1 << (8 * nb));
            mem_dataout = v[31:0];
        end else begin
            for (int i = 0; i < nb; i++)
                ram[(int'(mem_address[7:0]) + i) % 256] = 8'(mem_datain >> (8 * (nb - 1 - i)));
        end
        mem_moc = 1'b1;
    endtask

    task automatic run_access(input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input int d, input bit stale,
                              input string tag);
        bit          legal, ld, sg, seen;
        int          nb, exp_lat, exp_mov, lat, mov_hi;
        logic [1:0]  exp_err;
        logic [31:0] exp_rd;
        longint      v;
        op_info(op, legal, nb, ld, sg);
        exp_rd = ref_rdata;
        if (!legal) begin
            exp_err = 2'b11; exp_lat = 1; exp_mov = 0;
        end else if ((a % nb) != 0) begin
            exp_err = 2'b01; exp_lat = 1; exp_mov = 0;
        end else if (d >= c_TO) begin
            exp_err = 2'b10; exp_lat = c_TO + 1; exp_mov = c_TO;
        end else begin
            exp_err = 2'b00; exp_lat = d + 2; exp_mov = d + 1;
            if (ld) begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v * 256 + longint'(ref_mem[(a + i) % 256]);
                if (sg && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
                exp_rd = v[31:0];
            end else begin
                for (int i = 0; i < nb; i++)
                    ref_mem[(a + i) % 256] = 8'(wd >> (8 * (nb - 1 - i)));
            end
        end

        req = 1'b1; op3 = op; addr = a; wdata = wd;
        lat = 0; mov_hi = 0; seen = 1'b0;
        while (!seen && lat < 64) begin
            step();
            lat++;
            mem_moc = 1'b0;
            if (done || err_v) begin
                seen = 1'b1;
            end else begin
                if (mem_mov) mov_hi++;
                if (lat == 1 && exp_err == 2'b00) begin
                    chk({tag, " rw"}, 32'(mem_rw), 32'(ld));
                    chk({tag, " size"}, 32'(mem_size), (nb == 1) ? 0 : (nb == 2) ? 1 : 2);
                    chk({tag, " sign"}, 32'(mem_sign), 32'(sg));
                    chk({tag, " address"}, mem_address, a);
                    if (!ld) chk({tag, " datain"}, mem_datain, wd);
                end
                if (mem_mov && (lat - 1) == d) ram_respond();
                else if (mem_mov && stale && lat == 1) begin
                    mem_dataout = 32'hDEAD_0BAD;
                    mem_moc = 1'b1;
                end
            end
        end
        req = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " done"}, 32'(done), 32'(exp_err == 2'b00));
        chk({tag, " err_v"}, 32'(err_v), 32'(exp_err != 2'b00));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " rdata"}, rdata, exp_rd);
        chk({tag, " mov low at end"}, 32'(mem_mov), 0);
        chk({tag, " mov cycles"}, 32'(mov_hi), 32'(exp_mov));
        last_err = err;
        last_rd  = rdata;
        ref_rdata = exp_rd;
        step();
        chk({tag, " idle busy"}, 32'(busy), 0);
        chk({tag, " single pulse"}, 32'(done | err_v), 0);
    endtask

    vec_t       vecs[$];
    logic [5:0] legal_ops[8];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[0] = 8'h12; ram[1] = 8'h34; ram[2] = 8'h56; ram[3] = 8'h78; ram[5] = 8'h80;
        for (int i = 0; i < 6; i++) ref_mem[i] = ram[i];

        vecs.push_back('{6'b000000, 32'h00, 32'h0,         1,  1'b0, 2'b00, 32'h12345678});
        vecs.push_back('{6'b001001, 32'h05, 32'h0,         1,  1'b0, 2'b00, 32'hFFFFFF80});
        vecs.push_back('{6'b000001, 32'h05, 32'h0,         2,  1'b0, 2'b00, 32'h00000080});
        vecs.push_back('{6'b000110, 32'h0A, 32'h0000BEEF,  1,  1'b0, 2'b00, 32'h00000080});
        vecs.push_back('{6'b000010, 32'h0A, 32'h0,         3,  1'b0, 2'b00, 32'h0000BEEF});
        vecs.push_back('{6'b000000, 32'h06, 32'h0,         1,  1'b0, 2'b01, 32'h0000BEEF});
        vecs.push_back('{6'b000110, 32'h03, 32'h1234,      1,  1'b0, 2'b01, 32'h0000BEEF});
        vecs.push_back('{6'b111111, 32'h00, 32'h0,         1,  1'b0, 2'b11, 32'h0000BEEF});
        vecs.push_back('{6'b111111, 32'h01, 32'h0,         1,  1'b0, 2'b11, 32'h0000BEEF});
        vecs.push_back('{6'b000000, 32'h00, 32'h0,         4,  1'b1, 2'b00, 32'h12345678});
        vecs.push_back('{6'b000100, 32'h10, 32'hCAFEF00D,  2,  1'b0, 2'b00, 32'h12345678});
        vecs.push_back('{6'b001010, 32'h10, 32'h0,         1,  1'b1, 2'b00, 32'hFFFFCAFE});
        vecs.push_back('{6'b000000, 32'h10, 32'h0,         c_TO - 1, 1'b0, 2'b00, 32'hCAFEF00D});
        vecs.push_back('{6'b000000, 32'h00, 32'h0,         99, 1'b0, 2'b10, 32'hCAFEF00D});

        reset_n = 1'b0;
        step(); step();
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset err_v", 32'(err_v), 0);
        chk("reset err", 32'(err), 0);
        chk("reset rdata", rdata, 0);
        chk("reset mov", 32'(mem_mov), 0);
        chk("reset rw", 32'(mem_rw), 0);
        chk("reset size", 32'(mem_size), 0);
        chk("reset sign", 32'(mem_sign), 0);
        chk("reset address", mem_address, 0);
        chk("reset datain", mem_datain, 0);
        reset_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            run_access(vecs[i].op, vecs[i].a, vecs[i].wd, vecs[i].d, vecs[i].stale,
                       $sformatf("vec%0d", i));
            chk($sformatf("vec%0d table err", i), 32'(last_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d table rdata", i), last_rd, vecs[i].exp_rd);
        end

        // Reset on the third WAIT cycle of a load that never sees MOC
        req = 1'b1; op3 = 6'b000000; addr = 32'h0;
        step(); step(); step();
        chk("midreset mov before", 32'(mem_mov), 1);
        reset_n = 1'b0; req = 1'b0;
        step();
        chk("midreset mov", 32'(mem_mov), 0);
        chk("midreset busy", 32'(busy), 0);
        chk("midreset pulse", 32'(done | err_v), 0);
        chk("midreset rdata", rdata, 0);
        reset_n = 1'b1;
        ref_rdata = 32'h0;
        step();
        chk("after reset pulse", 32'(done | err_v), 0);
        run_access(6'b000000, 32'h0, 32'h0, 1, 1'b0, "post-reset LD");
        chk("post-reset rdata", rdata, 32'h12345678);

        legal_ops = '{6'b001001, 6'b001010, 6'b000001, 6'b000010,
                      6'b000000, 6'b000101, 6'b000110, 6'b000100};
        for (int n = 0; n < 200; n++) begin
            logic [5:0]  rop;
            logic [31:0] ra;
            int          rd;
            rop = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 7)] : 6'($urandom);
            ra  = $urandom_range(0, 62) * 4;
            if ($urandom_range(0, 3) == 0) ra = ra + $urandom_range(1, 3);
            rd  = ($urandom_range(0, 15) == 0) ? c_TO + 3 : $urandom_range(1, 4);
            run_access(rop, ra, $urandom, rd, $urandom_range(0, 3) == 0,
                       $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
